// File: rtl/reg_writeback_queue_if.sv
// Producer/register-file handshake bundle for the writeback queue.
// slave = queue side, master = producer and register-file side.
interface reg_writeback_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [63:0]   in_data;
  logic          wb_en;
  logic          wb_ready;
  logic [4:0]    wb_rd;
  logic [63:0]   wb_data;
  logic [31:0]   pending_mask;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_data, wb_ready,
    output in_ready, wb_en, wb_rd, wb_data, pending_mask, count
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_data, wb_ready,
    input  in_ready, wb_en, wb_rd, wb_data, pending_mask, count
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// FIFO of formatted register writebacks with a pending-destination scoreboard mask.
// Data is formatted at push so the head can drive the register file directly.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_writeback_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_rd_mem   [DEPTH];
  logic [63:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_nonempty;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_fmt;
  logic [31:0]   w_mask;

  function automatic logic [63:0] fmt_wb(input logic [5:0] op, input logic [63:0] d);
    case (op)
      6'd34:   fmt_wb = {56'b0, d[7:0]};
      6'd40:   fmt_wb = {48'b0, d[15:0]};
      6'd42:   fmt_wb = {{48{d[15]}}, d[15:0]};
      6'd32:   fmt_wb = {32'b0, d[31:0]};
      default: fmt_wb = d;
    endcase
  endfunction

  assign w_nonempty = (r_count != '0);
  // in_ready looks only at count, so a full queue refuses even when popping
  assign w_push     = bus.in_valid && bus.in_ready;
  assign w_pop      = w_nonempty && bus.wb_ready;
  assign w_fmt      = fmt_wb(bus.in_opcode, bus.in_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; count gating keeps stale slots invisible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wptr]   <= bus.in_rd;
      r_data_mem[r_wptr] <= w_fmt;
    end
  end

  // A slot is live when its distance from the head is below count.
  always_comb begin
    logic [AW-1:0] v_off;
    w_mask = '0;
    v_off  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      v_off = AW'(j) - r_rptr;
      if ({1'b0, v_off} < r_count) w_mask[r_rd_mem[j]] = 1'b1;
    end
  end

  assign bus.in_ready     = (r_count < CW'(DEPTH));
  assign bus.wb_en        = w_nonempty;
  assign bus.wb_rd        = w_nonempty ? r_rd_mem[r_rptr]   : 5'd0;
  assign bus.wb_data      = w_nonempty ? r_data_mem[r_rptr] : 64'd0;
  assign bus.pending_mask = w_mask;
  assign bus.count        = r_count;
endmodule
